// File: rtl/mips_avalon_mem.sv
// Avalon-MM slave memory behind the MIPS bus master: data RAM at 0x0, reset-vector ROM at 0xBFC00000,
// programmable wait states through a registered waitrequest, and a sticky fault flag for bad transfers.
//
// state | meaning
// IDLE  | waiting for read/write; request is latched here
// WAIT  | counting down the programmed wait states
// ACK   | waitrequest low for one cycle; readdata valid, write commits at the end
module mips_avalon_mem #(
  parameter int    RAM_AW        = 12,
  parameter int    ROM_AW        = 10,
  parameter int    WAIT_CYCLES   = 2,
  parameter string RAM_INIT_FILE = "",
  parameter string ROM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [31:0]          ROM_BASE = 32'hBFC00000;
  localparam logic [29-ROM_AW:0]   ROM_TAG  = ROM_BASE[31:ROM_AW+2];

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        drop;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_rd, lat_wr;
  logic [3:0]  lat_be;

  logic [31:0] ram_mem [2**RAM_AW];
  logic [31:0] rom_mem [2**ROM_AW];

  // With zero wait states ACK follows IDLE directly, so decode the live request in IDLE.
  logic [31:0]       cur_addr;
  logic              cur_rd, cur_wr;
  logic              cur_ram_hit, cur_rom_hit, lat_ram_hit;
  logic [RAM_AW-1:0] cur_ram_idx, lat_ram_idx;
  logic [ROM_AW-1:0] cur_rom_idx;
  logic [31:0]       cur_word;
  logic              xfer_err;

  assign cur_addr    = (state == IDLE) ? address : lat_addr;
  assign cur_rd      = (state == IDLE) ? read    : lat_rd;
  assign cur_wr      = (state == IDLE) ? write   : lat_wr;
  assign cur_ram_hit = (cur_addr[31:RAM_AW+2] == '0);
  assign cur_rom_hit = (cur_addr[31:ROM_AW+2] == ROM_TAG);
  assign cur_ram_idx = cur_addr[RAM_AW+1:2];
  assign cur_rom_idx = cur_addr[ROM_AW+1:2];
  assign lat_ram_hit = (lat_addr[31:RAM_AW+2] == '0);
  assign lat_ram_idx = lat_addr[RAM_AW+1:2];

  always_comb begin
    cur_word = '0;
    if (!(cur_rd && cur_wr)) begin
      if (cur_ram_hit)      cur_word = ram_mem[cur_ram_idx];
      else if (cur_rom_hit) cur_word = rom_mem[cur_rom_idx];
    end
  end

  assign xfer_err = (!cur_ram_hit && !cur_rom_hit) || (cur_addr[1:0] != 2'b00) ||
                    (cur_rd && cur_wr) || (cur_wr && cur_rom_hit);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (read || write) begin
          cnt_nx   = 4'(WAIT_CYCLES);
          state_nx = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!read && !write) begin
          drop     = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      waitrequest <= 1'b1;
      readdata    <= '0;
      fault       <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_rd      <= 1'b0;
      lat_wr      <= 1'b0;
      lat_be      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      waitrequest <= (state_nx != ACK);
      if (state == IDLE && (read || write)) begin
        lat_addr  <= address;
        lat_wdata <= writedata;
        lat_rd    <= read;
        lat_wr    <= write;
        lat_be    <= byteenable;
      end
      if (state_nx == ACK) begin
        readdata <= cur_word;
        if (xfer_err) fault <= 1'b1;
      end
      if (drop) fault <= 1'b1;
    end
  end

  // RAM is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (state == ACK && lat_wr && !lat_rd && lat_ram_hit && lat_be[i])
        ram_mem[lat_ram_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mips_avalon_mem.sv
// Directed bench for mips_avalon_mem: three instances (2, 0 and 3 wait states) share one request bus;
// sel picks which instance's outputs are observed.
module tb_mips_avalon_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;

  logic        w2_wr, w0_wr, w3_wr, w2_f, w0_f, w3_f;
  logic [31:0] w2_rd, w0_rd, w3_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 2;

  always #5 clk = ~clk;

  mips_avalon_mem #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(w2_wr), .readdata(w2_rd), .fault(w2_f));

  mips_avalon_mem #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(w0_wr), .readdata(w0_rd), .fault(w0_f));

  mips_avalon_mem #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(w3_wr), .readdata(w3_rd), .fault(w3_f));

  logic        wreq, flt;
  logic [31:0] rdat;

  always_comb begin
    wreq = w2_wr; rdat = w2_rd; flt = w2_f;
    case (sel)
      0: begin wreq = w0_wr; rdat = w0_rd; flt = w0_f; end
      3: begin wreq = w3_wr; rdat = w3_rd; flt = w3_f; end
      default: ;
    endcase
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Enter and leave at posedge+1; reset values are checked while reset is held.
  task automatic reset_dut();
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("reset_waitrequest", {31'b0, wreq}, 32'd1);
    chk("reset_readdata", rdat, 32'h0);
    chk("reset_fault", {31'b0, flt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input int exp_hi, output logic [31:0] rdv);
    int  hi;
    bit  done;
    hi = 0; done = 0; rdv = '0;
    address = a; read = r; write = w; byteenable = be; writedata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!wreq) begin
        rdv  = rdat;
        done = 1;
      end else begin
        hi++;
      end
    end
    chk("xfer_ack_seen", {31'b0, done}, 32'd1);
    chk("xfer_wait_cycles", hi, exp_hi);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  logic [31:0] rv;
  logic        saw_low;
  logic        exp_wr_pat[4];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0,        32'h3C021234};
    vecs[1]  = '{1'b0, 1'b1, 32'h00000010, 4'hF, 32'hAABBCCDD, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h00000010, 4'h5, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000010, 4'hF, 32'h0,        32'hAA22CC44};
    vecs[4]  = '{1'b0, 1'b1, 32'h00000000, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000004, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h00000000, 4'h1, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h00000004, 4'h0, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000004, 4'h0, 32'h00000000, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000004, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b1, 32'h00000004, 4'h4, 32'h00AB0000, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h00000004, 4'hF, 32'h0,        32'hCAABF00D};
    vecs[12] = '{1'b0, 1'b1, 32'h00003FFC, 4'hF, 32'h13579BDF, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h00003FFC, 4'hF, 32'h0,        32'h13579BDF};

    u_w2.rom_mem[0] = 32'h3C021234;
    u_w2.rom_mem[1] = 32'h08000000;

    // Table-driven transfers on the 2-wait-state instance.
    sel = 2;
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata, 3, rv);
      if (vecs[i].rd) chk($sformatf("vec%0d_readdata", i), rv, vecs[i].exp);
      chk($sformatf("vec%0d_fault", i), {31'b0, flt}, 32'd0);
    end
    xfer(1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h0, 3, rv);
    chk("rom_word1", rv, 32'h08000000);

    // ROM write is dropped and faults.
    reset_dut();
    xfer(1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'hFFFFFFFF, 3, rv);
    chk("rom_write_fault", {31'b0, flt}, 32'd1);
    reset_dut();
    xfer(1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 3, rv);
    chk("rom_unchanged", rv, 32'h3C021234);
    chk("rom_read_no_fault", {31'b0, flt}, 32'd0);

    // Unmapped read.
    reset_dut();
    xfer(1'b1, 1'b0, 32'h80000000, 4'hF, 32'h0, 3, rv);
    chk("unmapped_readdata", rv, 32'h0);
    chk("unmapped_fault", {31'b0, flt}, 32'd1);

    // Misaligned read still returns the word.
    reset_dut();
    xfer(1'b1, 1'b0, 32'h00000002, 4'hF, 32'h0, 3, rv);
    chk("misaligned_readdata", rv, 32'hDEADBEEF);
    chk("misaligned_fault", {31'b0, flt}, 32'd1);

    // Read and write together: no memory change, readdata zero.
    reset_dut();
    xfer(1'b1, 1'b1, 32'h00000000, 4'hF, 32'h55555555, 3, rv);
    chk("rdwr_readdata", rv, 32'h0);
    chk("rdwr_fault", {31'b0, flt}, 32'd1);
    reset_dut();
    xfer(1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, 3, rv);
    chk("rdwr_mem_unchanged", rv, 32'hDEADBEEF);

    // Request dropped during WAIT.
    reset_dut();
    address = 32'h0; read = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    read = 1'b0;
    saw_low = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!wreq) saw_low = 1'b1;
    end
    chk("drop_no_ack", {31'b0, saw_low}, 32'd0);
    chk("drop_fault", {31'b0, flt}, 32'd1);

    // Zero wait states, back-to-back reads with read held.
    sel = 0;
    reset_dut();
    xfer(1'b0, 1'b1, 32'h0, 4'hF, 32'h11111111, 1, rv);
    xfer(1'b0, 1'b1, 32'h4, 4'hF, 32'h22222222, 1, rv);
    exp_wr_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    address = 32'h0; read = 1'b1; byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_waitrequest%0d", k), {31'b0, wreq}, {31'b0, exp_wr_pat[k]});
      if (k == 1) chk("b2b_word0", rdat, 32'h11111111);
      if (k == 3) chk("b2b_word1", rdat, 32'h22222222);
      if (k == 1) begin
        @(posedge clk); #1;
        address = 32'h4;
      end
    end
    @(posedge clk); #1;
    read = 1'b0;
    chk("b2b_fault", {31'b0, flt}, 32'd0);

    // Reset asserted mid-write on the 3-wait-state instance.
    sel = 3;
    reset_dut();
    xfer(1'b0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, 4, rv);
    xfer(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 4, rv);
    chk("midrst_pre_read", rv, 32'hA5A5A5A5);
    address = 32'h20; write = 1'b1; writedata = 32'h12345678; byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_waitrequest", {31'b0, wreq}, 32'd1);
    chk("midrst_readdata", rdat, 32'h0);
    write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 4, rv);
    chk("midrst_old_value", rv, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_avalon_mem.md
Name: mips_avalon_mem

Overview:
- Avalon-MM slave memory directly downstream of the MIPS CPU bus master.
- Serves instruction fetches and data loads/stores from two regions:
  - a reset-vector ROM at 0xBFC00000;
  - a data RAM at 0x00000000.
- Inserts a programmable number of wait states through waitrequest, so the CPU's stall logic is exercised.
- Flags protocol and decode errors on a sticky fault output instead of hanging the bus.

Parameters:
- RAM_AW, 12: RAM address width in words. RAM size is 2^RAM_AW words.
- ROM_AW, 10: ROM address width in words.
- WAIT_CYCLES, 2: extra wait states per transfer, range 0..15.
- RAM_INIT_FILE, "": hex image loaded into the RAM at elaboration; empty means all zero.
- ROM_INIT_FILE, "": hex image loaded into the ROM at elaboration; empty means all zero.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- address, in, 32: byte address from the master.
- read, in, 1: read request.
- write, in, 1: write request.
- byteenable, in, 4: lane i covers bits 8i+7:8i.
- writedata, in, 32: write data.
- waitrequest, out, 1: high means the master must hold its request.
- readdata, out, 32: read data, valid only when waitrequest is low during a read.
- fault, out, 1: sticky error flag.

Behaviour:
- Reset values: waitrequest=1, readdata=0, fault=0, state=IDLE, wait counter=0. Memory contents are not cleared by reset.
- waitrequest is a register. It is low only in the ACK state and high in every other state, including idle.
- State machine:
  - IDLE: when read or write is high, latch address, read, write, byteenable and writedata; load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else to ACK.
  - WAIT: decrement the counter each cycle. Go to ACK after the cycle in which the counter is 1. If read and write are both low (request dropped), set fault and go to IDLE.
  - ACK: waitrequest=0 and readdata presents the latched-address word. A write commits at the rising edge that ends ACK. Next state is always IDLE.
- Latency: every transfer holds waitrequest high for WAIT_CYCLES+1 cycles, then low for exactly 1 cycle. Back-to-back requests therefore cost WAIT_CYCLES+2 cycles each.
- Decode, using the latched address:
  - RAM hit: address[31:2] < 2^RAM_AW. Index is address[RAM_AW+1:2].
  - ROM hit: address[31:ROM_AW+2] == 0xBFC00000 >> (ROM_AW+2). Index is address[ROM_AW+1:2].
  - Anything else is unmapped: read returns 0, write is dropped, fault=1. The transfer is still acknowledged.
- Alignment: address[1:0] is ignored for indexing. A non-zero value sets fault; the access still proceeds at the word address.
- Writes: only lanes with byteenable[i]=1 are updated. byteenable=0000 is a legal no-op. Writes to ROM are dropped and set fault.
- Reads: always return the full 32-bit word regardless of byteenable. The master extracts bytes and halves itself.
- read and write both high: fault=1, no memory change, readdata=0, transfer still acknowledged.
- Request changes while waitrequest is high: ignored. The latched values are used.
- fault is cleared only by reset.
- Reset asserted mid-transfer: immediately go to IDLE with waitrequest=1. No partial write occurs. readdata returns to 0.
- readdata holds its last value outside ACK. The master must not sample it outside ACK.

Test Plan:
- ROM fetch: ROM_INIT_FILE word0=0x3C021234, WAIT_CYCLES=2. Read 0xBFC00000.
  -> waitrequest high 3 cycles, then low 1 cycle with readdata=0x3C021234; fault=0.
- Byte-lane write: write 0xAABBCCDD to 0x00000010 with byteenable=1111, then 0x11223344 with byteenable=0101; read back.
  -> readdata=0xAA22CC44.
- Zero wait states: WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with read held high.
  -> waitrequest pattern 1,0,1,0; each ACK carries the correct word.
- Error paths, each checked in a separate run:
  - write 0xFFFFFFFF to 0xBFC00000 -> ROM unchanged, fault=1;
  - read 0x80000000 -> readdata=0, fault=1;
  - read 0x00000002 -> fault=1 and the word at 0x0 is returned.
- Reset mid-write: start a write of 0x12345678 to 0x20 with WAIT_CYCLES=3; pull reset low during WAIT; release; read 0x20.
  -> old value returned; waitrequest=1 and readdata=0 while reset is low.
- CPU integration: connect to the CPU with a ROM program that runs LUI $2,0x1234 then jumps to 0x0.
  -> register_v0=0x12340000 when active falls; fault=0.
